// File: rtl/e_mdu_pkg.sv
// Shared multiply/divide op encodings, FSM states and default latencies.
// Included by the control decoder and the E-stage multiply/divide unit.
package e_mdu_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   localparam int unsigned MD_MULT_CYCLES_DEF = 5;
   localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

   function automatic logic md_is_arith(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_mult(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div as fixed-latency ops.
// Result lands in HI/LO MULT_CYCLES/DIV_CYCLES after start; busy holds off new ops.
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_mdOp,
   input  logic [31:0] E_rs,
   input  logic [31:0] E_rt,
   input  logic        req,
   output logic        start,
   output logic        busy,
   output logic [31:0] E_mdOut,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W = $clog2(MAX_CYCLES + 1);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      tmp_hi_q, tmp_hi_d;
   logic [31:0]      tmp_lo_q, tmp_lo_d;

   // Multiplier: sign-extend to 64 bits so the low 64 bits of the product are exact.
   logic signed [63:0] rs_sx, rt_sx, prod_s;
   logic [63:0]        prod_u;

   assign rs_sx  = {{32{E_rs[31]}}, E_rs};
   assign rt_sx  = {{32{E_rt[31]}}, E_rt};
   assign prod_s = rs_sx * rt_sx;
   assign prod_u = {32'd0, E_rs} * {32'd0, E_rt};

   // Signed divide in magnitude form keeps INT_MIN / -1 well-defined (quotient wraps to INT_MIN).
   logic [31:0] rs_mag, rt_mag, sdiv_den, udiv_den;
   logic [31:0] squo_mag, srem_mag, squo, srem, uquo, urem;
   logic        div_by_zero;

   assign rs_mag      = E_rs[31] ? (~E_rs + 32'd1) : E_rs;
   assign rt_mag      = E_rt[31] ? (~E_rt + 32'd1) : E_rt;
   assign div_by_zero = (E_rt == 32'd0);
   assign sdiv_den    = div_by_zero ? 32'd1 : rt_mag;
   assign udiv_den    = div_by_zero ? 32'd1 : E_rt;
   assign squo_mag    = rs_mag / sdiv_den;
   assign srem_mag    = rs_mag % sdiv_den;
   assign squo        = (E_rs[31] ^ E_rt[31]) ? (~squo_mag + 32'd1) : squo_mag;
   assign srem        = E_rs[31] ? (~srem_mag + 32'd1) : srem_mag;
   assign uquo        = E_rs / udiv_den;
   assign urem        = E_rs % udiv_den;

   assign busy  = (count_q != '0);
   assign start = md_is_arith(E_mdOp) && !req && !busy;

   always_comb begin
      E_mdOut = 32'd0;
      if (E_mdOp == MD_MFHI) begin
         E_mdOut = hi_q;
      end else if (E_mdOp == MD_MFLO) begin
         E_mdOut = lo_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      tmp_hi_d = tmp_hi_q;
      tmp_lo_d = tmp_lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               count_d = md_is_mult(E_mdOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
               // Divide by zero still burns the full latency but commits the current HI/LO.
               tmp_hi_d = hi_q;
               tmp_lo_d = lo_q;
               case (E_mdOp)
                  MD_MULT:  {tmp_hi_d, tmp_lo_d} = prod_s;
                  MD_MULTU: {tmp_hi_d, tmp_lo_d} = prod_u;
                  MD_DIV: begin
                     if (!div_by_zero) begin
                        tmp_hi_d = srem;
                        tmp_lo_d = squo;
                     end
                  end
                  MD_DIVU: begin
                     if (!div_by_zero) begin
                        tmp_hi_d = urem;
                        tmp_lo_d = uquo;
                     end
                  end
                  default: ;
               endcase
            end else if (!req && (E_mdOp == MD_MTHI)) begin
               hi_d = E_rs;
            end else if (!req && (E_mdOp == MD_MTLO)) begin
               lo_d = E_rs;
            end
         end
         ST_RUN: begin
            if (count_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               count_d = '0;
               hi_d    = tmp_hi_q;
               lo_d    = tmp_lo_q;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         tmp_hi_q <= 32'd0;
         tmp_lo_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         tmp_hi_q <= tmp_hi_d;
         tmp_lo_q <= tmp_lo_d;
      end
   end

   assign HI = hi_q;
   assign LO = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: vector table of mult/div ops plus hand sequences for
// mthi/mtlo with flush, reset mid-divide, and ops presented while busy.
module tb_e_mdu;
   import e_mdu_pkg::*;

   logic        clk;
   logic        reset;
   logic [3:0]  E_mdOp;
   logic [31:0] E_rs;
   logic [31:0] E_rt;
   logic        req;
   logic        start;
   logic        busy;
   logic [31:0] E_mdOut;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_vec = 0;
   int n_err = 0;

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .E_mdOp  (E_mdOp),
      .E_rs    (E_rs),
      .E_rt    (E_rt),
      .req     (req),
      .start   (start),
      .busy    (busy),
      .E_mdOut (E_mdOut),
      .HI      (HI),
      .LO      (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } vec_t;

   localparam int NVEC = 11;
   vec_t tbl [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue an op at a negedge, measure busy length, then check HI/LO and mfhi/mflo.
   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int exp_n);
      int n;
      @(negedge clk);
      E_mdOp = op; E_rs = rs; E_rt = rt; req = 1'b0;
      #1;
      chk({name, " start"}, {31'd0, start}, 32'd1);
      @(posedge clk); #1;
      E_mdOp = MD_NONE;
      n = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      chk({name, " busy_cycles"}, 32'(n), 32'(exp_n));
      chk({name, " HI"}, HI, exp_hi);
      chk({name, " LO"}, LO, exp_lo);
      E_mdOp = MD_MFHI; #1;
      chk({name, " mfhi"}, E_mdOut, exp_hi);
      E_mdOp = MD_MFLO; #1;
      chk({name, " mflo"}, E_mdOut, exp_lo);
      E_mdOp = MD_NONE;
   endtask

   initial begin
      int n;
      tbl[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
      tbl[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
      tbl[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      tbl[3]  = '{MD_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      tbl[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
      tbl[5]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
      tbl[6]  = '{MD_DIVU,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, 10};
      tbl[7]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
      tbl[8]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
      tbl[9]  = '{MD_DIV,   32'd5,        32'd0,        32'hFFFFFFFE, 32'h00000001, 10};
      tbl[10] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};

      reset = 1'b0; E_mdOp = MD_NONE; E_rs = '0; E_rt = '0; req = 1'b0;
      #12;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset HI", HI, 32'd0);
      chk("reset LO", LO, 32'd0);
      E_mdOp = MD_MFHI; #1;
      chk("reset mfhi", E_mdOut, 32'd0);
      E_mdOp = MD_NONE;
      @(negedge clk); reset = 1'b1;
      #1;
      chk("post-reset start idle", {31'd0, start}, 32'd0);

      for (int i = 0; i < NVEC; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].rs, tbl[i].rt,
                tbl[i].hi, tbl[i].lo, tbl[i].n);
      end

      // mtlo under flush is dropped; without flush it lands next cycle.
      @(negedge clk);
      E_mdOp = MD_MTLO; E_rs = 32'h12345678; req = 1'b1; #1;
      chk("mtlo req start", {31'd0, start}, 32'd0);
      @(posedge clk); #1;
      E_mdOp = MD_NONE; req = 1'b0;
      @(negedge clk);
      chk("mtlo req LO held", LO, tbl[NVEC-1].lo);
      E_mdOp = MD_MTLO; E_rs = 32'h12345678;
      @(posedge clk); #1;
      E_mdOp = MD_MFLO; #1;
      chk("mtlo LO", LO, 32'h12345678);
      chk("mtlo mflo", E_mdOut, 32'h12345678);
      E_mdOp = MD_MTHI; E_rs = 32'hCAFEF00D;
      @(posedge clk); #1;
      E_mdOp = MD_MFHI; #1;
      chk("mthi mfhi", E_mdOut, 32'hCAFEF00D);
      E_mdOp = MD_NONE;

      // Reset pulsed four cycles into a divide clears everything immediately.
      @(negedge clk);
      E_mdOp = MD_DIV; E_rs = 32'hFFFFFFF9; E_rt = 32'd2;
      @(posedge clk); #1;
      E_mdOp = MD_NONE;
      repeat (3) @(posedge clk);
      #2;
      chk("pre-reset busy", {31'd0, busy}, 32'd1);
      reset = 1'b0; #1;
      chk("midrun reset busy", {31'd0, busy}, 32'd0);
      chk("midrun reset HI", HI, 32'd0);
      chk("midrun reset LO", LO, 32'd0);
      @(negedge clk); reset = 1'b1;
      run_op("mult after reset", MD_MULT, 32'd6, 32'd7, 32'd0, 32'h0000002A, 5);

      // mthi and a second mult during busy are ignored; flush does not abort the run.
      @(negedge clk);
      E_mdOp = MD_MULT; E_rs = 32'd3; E_rt = 32'd4;
      @(posedge clk); #1;
      E_mdOp = MD_NONE; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0; E_mdOp = MD_MTHI; E_rs = 32'hDEADBEEF; #1;
      chk("mthi busy start", {31'd0, start}, 32'd0);
      @(posedge clk); #1;
      E_mdOp = MD_MULT; E_rs = 32'd100; E_rt = 32'd100; #1;
      chk("mult busy start", {31'd0, start}, 32'd0);
      @(posedge clk); #1;
      E_mdOp = MD_NONE;
      n = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      chk("busy ops remaining cycles", 32'(n), 32'd2);
      chk("busy ops HI", HI, 32'd0);
      chk("busy ops LO", LO, 32'd12);
      E_mdOp = MD_DIVU; E_rs = 32'd1; E_rt = 32'd1; #1;
      chk("back-to-back start", {31'd0, start}, 32'd1);
      E_mdOp = MD_NONE;
      @(posedge clk); #1;
      @(negedge clk);
      chk("no late start busy", {31'd0, busy}, 32'd0);
      chk("no late start LO", LO, 32'd12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
